// File: rtl/onehot_pkg.sv
// Shared defaults, decoded-word type and the index-to-onehot/mask decoder
// for the one-hot decode stream.
package onehot_pkg;

  localparam int unsigned N_DEF     = 32;
  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned IDX_W     = $clog2(N_DEF);

  // Decoded words are built at the widest supported size; users keep the low N bits.
  localparam int unsigned VEC_MAX   = 32;
  localparam int unsigned VEC_IDX_W = $clog2(VEC_MAX);

  typedef struct packed {
    logic [VEC_MAX-1:0] onehot;
    logic [VEC_MAX-1:0] mask;
  } dec_word_t;

  // An out-of-range index decodes exactly like an empty word.
  function automatic dec_word_t decode_word(input logic               zero,
                                            input logic [VEC_MAX-1:0] idx,
                                            input int unsigned        n);
    dec_word_t w;
    if (zero || (idx >= n)) begin
      w.onehot = '0;
      w.mask   = '1;
    end else begin
      w.onehot = VEC_MAX'(1) << idx[VEC_IDX_W-1:0];
      w.mask   = w.onehot - VEC_MAX'(1);
    end
    return w;
  endfunction

endpackage

// File: rtl/pipe_reg_slice.sv
// Single-entry valid/ready register slice; accepts a new word whenever it is
// empty or its current word leaves in the same cycle.
module pipe_reg_slice #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (in_ready_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/onehot_decode_stream.sv
// Two-stage streaming decoder: S1 registers {zero, idx}, S2 registers the
// decoded one-hot vector and lower-bit priority mask; counts delivered words.
module onehot_decode_stream
  import onehot_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_zero,
  input  logic [$clog2(N)-1:0] in_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_onehot,
  output logic [N-1:0]         out_mask,
  output logic [CNT_W-1:0]     dec_count
);

  localparam int unsigned IW   = $clog2(N);
  localparam int unsigned S1_W = IW + 1;
  localparam int unsigned S2_W = 2 * N;

  logic            s1_valid, s1_ready;
  logic [S1_W-1:0] s1_data;
  logic [S2_W-1:0] s2_in, s2_out;
  dec_word_t       dec;

  pipe_reg_slice #(
    .W(S1_W)
  ) u_s1 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  ({in_zero, in_idx}),
    .out_valid_o(s1_valid),
    .out_ready_i(s1_ready),
    .out_data_o (s1_data)
  );

  always_comb begin
    dec   = decode_word(s1_data[IW], VEC_MAX'(s1_data[IW-1:0]), N);
    s2_in = {dec.onehot[N-1:0], dec.mask[N-1:0]};
  end

  pipe_reg_slice #(
    .W(S2_W)
  ) u_s2 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .in_valid_i (s1_valid),
    .in_ready_o (s1_ready),
    .in_data_i  (s2_in),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (s2_out)
  );

  assign out_onehot = s2_out[S2_W-1:N];
  assign out_mask   = s2_out[N-1:0];

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid && out_ready && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign dec_count = cnt_q;

endmodule

// File: tb/tb_onehot_decode_stream.sv
// Self-checking bench for onehot_decode_stream: table vectors plus streaming,
// backpressure, async-reset and counter-saturation sequences via a scoreboard.
module tb_onehot_decode_stream;

  localparam int unsigned N     = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned IW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_zero, out_ready;
  logic [IW-1:0]    in_idx;
  logic             in_ready, out_valid, in_ready4, out_valid4;
  logic [N-1:0]     out_onehot, out_mask, oh4, mk4;
  logic [CNT_W-1:0] dec_count;
  logic [3:0]       dec_count4;

  always #5 clk = ~clk;

  onehot_decode_stream #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_zero(in_zero), .in_idx(in_idx), .out_valid(out_valid),
    .out_ready(out_ready), .out_onehot(out_onehot), .out_mask(out_mask),
    .dec_count(dec_count)
  );

  onehot_decode_stream #(.N(N), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_zero(in_zero), .in_idx(in_idx), .out_valid(out_valid4),
    .out_ready(out_ready), .out_onehot(oh4), .out_mask(mk4),
    .dec_count(dec_count4)
  );

  typedef struct packed {
    logic [N-1:0] oh;
    logic [N-1:0] mk;
  } exp_t;

  typedef struct {
    logic          zero;
    logic [IW-1:0] idx;
    exp_t          req;
  } vec_t;

  exp_t        sb_q[$];
  exp_t        cur_exp;
  vec_t        vecs[8];
  int          checks = 0;
  int          failures = 0;
  int unsigned cnt_exp, cnt4_exp, accepted, emitted, run_len, max_run;
  logic        prev_stall;
  logic [N-1:0] prev_oh, prev_mk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t ref_word(input logic zero, input logic [IW-1:0] idx);
    exp_t r;
    for (int j = 0; j < int'(N); j++) begin
      r.oh[j] = !zero && (j == int'(idx));
      r.mk[j] = zero || (j < int'(idx));
    end
    return r;
  endfunction

  function automatic vec_t mkvec(input logic zero, input logic [IW-1:0] idx,
                                 input logic [N-1:0] oh, input logic [N-1:0] mk);
    vec_t v;
    v.zero   = zero;
    v.idx    = idx;
    v.req.oh = oh;
    v.req.mk = mk;
    return v;
  endfunction

  // Called just before a rising edge: sees exactly the handshakes that edge will take.
  task automatic sample();
    exp_t e;
    logic [N:0] pre;
    if (prev_stall) begin
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_onehot", 64'(out_onehot), 64'(prev_oh));
      check("hold_mask", 64'(out_mask), 64'(prev_mk));
    end
    check("dec_count", 64'(dec_count), 64'(cnt_exp));
    check("dec_count4", 64'(dec_count4), 64'(cnt4_exp));
    if (out_valid) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      pre = {1'b0, out_onehot | out_mask};
      check("inv_disjoint", 64'(out_onehot & out_mask), 64'd0);
      check("inv_prefix", 64'((pre + 33'd1) & pre), 64'd0);
    end else begin
      run_len = 0;
    end
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0h required=none", out_onehot);
      end else begin
        e = sb_q.pop_front();
        check("out_onehot", 64'(out_onehot), 64'(e.oh));
        check("out_mask", 64'(out_mask), 64'(e.mk));
        check("out_valid4", 64'(out_valid4), 64'd1);
        check("out_onehot4", 64'(oh4), 64'(e.oh));
        check("out_mask4", 64'(mk4), 64'(e.mk));
      end
      emitted++;
      cnt_exp++;
      if (cnt4_exp < 15) cnt4_exp++;
    end
    if (in_valid && in_ready) begin
      check("in_ready4", 64'(in_ready4), 64'd1);
      sb_q.push_back(cur_exp);
      accepted++;
    end
    prev_stall = out_valid && !out_ready;
    prev_oh    = out_onehot;
    prev_mk    = out_mask;
  endtask

  // Entered and left on a falling edge.
  task automatic tick();
    #1;
    sample();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_zero   = 1'b0;
    in_idx    = '0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sb_q.delete();
    cnt_exp = 0; cnt4_exp = 0; prev_stall = 1'b0;
    run_len = 0; max_run = 0; accepted = 0; emitted = 0;
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic zero, input logic [IW-1:0] idx, input exp_t req);
    in_valid = 1'b1;
    in_zero  = zero;
    in_idx   = idx;
    cur_exp  = req;
  endtask

  task automatic send_word(input logic zero, input logic [IW-1:0] idx, input exp_t req);
    int unsigned a0;
    a0 = accepted;
    drive(zero, idx, req);
    for (int k = 0; k < 50 && accepted == a0; k++) tick();
    check("accept_timeout", 64'(accepted), 64'(a0 + 1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && sb_q.size() != 0; k++) tick();
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  logic [IW-1:0] bp_w[3];

  initial begin
    vecs[0] = mkvec(1'b0, 5'd0,  32'h0000_0001, 32'h0000_0000);
    vecs[1] = mkvec(1'b0, 5'd31, 32'h8000_0000, 32'h7FFF_FFFF);
    vecs[2] = mkvec(1'b1, 5'd0,  32'h0000_0000, 32'hFFFF_FFFF);
    vecs[3] = mkvec(1'b1, 5'd31, 32'h0000_0000, 32'hFFFF_FFFF);
    vecs[4] = mkvec(1'b0, 5'd5,  32'h0000_0020, 32'h0000_001F);
    vecs[5] = mkvec(1'b0, 5'd16, 32'h0001_0000, 32'h0000_FFFF);
    vecs[6] = mkvec(1'b0, 5'd1,  32'h0000_0002, 32'h0000_0001);
    vecs[7] = mkvec(1'b0, 5'd30, 32'h4000_0000, 32'h3FFF_FFFF);
    cur_exp = '0;

    // Reset state
    do_reset();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_onehot", 64'(out_onehot), 64'd0);
    check("rst_mask", 64'(out_mask), 64'd0);
    check("rst_count", 64'(dec_count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Two-cycle latency for the first word
    drive(1'b0, 5'd0, vecs[0].req);
    tick();
    in_valid = 1'b0;
    check("lat_cycle1_valid", 64'(out_valid), 64'd0);
    tick();
    check("lat_cycle2_valid", 64'(out_valid), 64'd1);
    check("lat_onehot", 64'(out_onehot), 64'h1);
    check("lat_mask", 64'(out_mask), 64'h0);
    tick();
    check("lat_count", 64'(dec_count), 64'd1);

    // Table vectors
    for (int v = 0; v < 8; v++) begin
      send_word(vecs[v].zero, vecs[v].idx, vecs[v].req);
      drain();
    end

    // Back-to-back stream of every index
    do_reset();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, IW'(i), ref_word(1'b0, IW'(i)));
      check("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
    end
    in_valid = 1'b0;
    drain();
    check("stream_run", 64'(max_run), 64'd32);
    check("stream_count", 64'(dec_count), 64'd32);

    // Backpressure: three words offered while the sink stalls
    do_reset();
    bp_w[0] = 5'd3; bp_w[1] = 5'd7; bp_w[2] = 5'd12;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (accepted < 3) drive(1'b0, bp_w[accepted], ref_word(1'b0, bp_w[accepted]));
      tick();
    end
    check("bp_accepted", 64'(accepted), 64'd2);
    check("bp_in_ready", 64'(in_ready), 64'd0);
    check("bp_out_valid", 64'(out_valid), 64'd1);
    check("bp_onehot", 64'(out_onehot), 64'h8);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && accepted < 3; c++) begin
      drive(1'b0, bp_w[accepted], ref_word(1'b0, bp_w[accepted]));
      tick();
    end
    in_valid = 1'b0;
    drain();
    check("bp_emitted", 64'(emitted), 64'd3);

    // Asynchronous reset with two words in flight
    do_reset();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive(1'b0, IW'(9 + 11 * c), ref_word(1'b0, IW'(9 + 11 * c)));
      tick();
    end
    in_valid = 1'b0;
    check("ar_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", 64'(out_valid), 64'd0);
    check("ar_onehot", 64'(out_onehot), 64'd0);
    check("ar_mask", 64'(out_mask), 64'd0);
    do_reset();
    for (int c = 0; c < 6; c++) tick();
    check("ar_no_output", 64'(emitted), 64'd0);
    check("ar_count", 64'(dec_count), 64'd0);

    // Counter saturation on the 4-bit instance
    do_reset();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, IW'(i), ref_word(1'b0, IW'(i)));
      tick();
    end
    in_valid = 1'b0;
    drain();
    tick();
    check("sat_count4", 64'(dec_count4), 64'd15);
    check("sat_count16", 64'(dec_count), 64'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
